// File: rtl/ysyx23060136_ifu_fetch_gen.sv
// ysyx23060136_ifu_fetch_gen: IFU1 front end.
// Owns the fetch PC and keeps at most one imem read in flight. Each returned
// word is placed in the output slot feeding the IFU1->IFU2 register. Branch
// redirects retarget fetch, and any response still in flight from before the
// redirect is discarded when it arrives.
module ysyx23060136_ifu_fetch_gen #(
    parameter int unsigned       BITS_W  = 32,
    parameter logic [BITS_W-1:0] PC_RST  = BITS_W'(32'h8000_0000),
    parameter int unsigned       PC_STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              BRANCH_flushIF,
    input  logic [BITS_W-1:0] BRANCH_target,
    input  logic              FORWARD_stallIF,
    output logic              imem_req_valid,
    output logic [BITS_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    input  logic              imem_resp_err,
    output logic [BITS_W-1:0] IFU1_pc,
    output logic [31:0]       IFU1_inst,
    output logic              IFU1_valid,
    output logic              IFU1_err
);

    localparam int unsigned       INST_W = 32;
    localparam logic [BITS_W-1:0] STEP   = BITS_W'(PC_STEP);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [BITS_W-1:0] fetch_pc_q;
    logic [BITS_W-1:0] fetch_pc_d;
    logic              kill_q;
    logic              kill_d;

    logic              req_valid_d;
    logic [BITS_W-1:0] req_addr_d;
    logic              slot_valid_d;
    logic              slot_err_d;
    logic [BITS_W-1:0] slot_pc_d;
    logic [INST_W-1:0] slot_inst_d;

    logic              redir;
    logic              consume;
    logic              req_hs;
    logic              inflight_after;

    // Pipeline events for this cycle; a flush under stall is not a redirect.
    assign redir   = BRANCH_flushIF & ~FORWARD_stallIF;
    assign consume = IFU1_valid & ~FORWARD_stallIF;
    assign req_hs  = imem_req_valid & imem_req_ready;

    // A read is still outstanding after this cycle if we are waiting without a
    // response, or a request is currently presented (handshaked now or later).
    assign inflight_after = ((state_q == ST_WAIT) && !imem_resp_valid) ||
                            ((state_q == ST_REQ) && imem_req_valid);

    // Next-state, fetch PC, kill flag, output slot and request register values.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        kill_d       = kill_q;
        slot_valid_d = IFU1_valid;
        slot_err_d   = IFU1_err;
        slot_pc_d    = IFU1_pc;
        slot_inst_d  = IFU1_inst;
        req_valid_d  = 1'b0;
        req_addr_d   = imem_req_addr;

        if (consume) begin
            slot_valid_d = 1'b0;
            slot_err_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (req_hs) begin
                    state_d = ST_WAIT;
                    // A killed request was issued at the old PC; fetch_pc already holds the target.
                    if (!kill_q) begin
                        fetch_pc_d = fetch_pc_q + STEP;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = ST_REQ;
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else begin
                        slot_valid_d = 1'b1;
                        slot_err_d   = imem_resp_err;
                        slot_pc_d    = imem_req_addr;
                        slot_inst_d  = imem_resp_data;
                        if (imem_resp_err) begin
                            state_d = ST_HALT;
                        end
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        // Redirect overrides everything: retarget, empty the slot, mark stale reads.
        if (redir) begin
            fetch_pc_d   = BRANCH_target;
            slot_valid_d = 1'b0;
            slot_err_d   = 1'b0;
            kill_d       = inflight_after;
            if (((state_q == ST_WAIT) && !imem_resp_valid) ||
                ((state_q == ST_REQ) && req_hs)) begin
                state_d = ST_WAIT;
            end else begin
                state_d = ST_REQ;
            end
        end

        // Request only into an empty slot so a returning word always has room.
        req_valid_d = (state_d == ST_REQ) && !slot_valid_d;
        // Address is latched when a new request is raised and held until handshake.
        if (req_valid_d && !(imem_req_valid && !req_hs)) begin
            req_addr_d = fetch_pc_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            fetch_pc_q     <= PC_RST;
            kill_q         <= 1'b0;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= PC_RST;
            IFU1_pc        <= PC_RST;
            IFU1_inst      <= '0;
            IFU1_valid     <= 1'b0;
            IFU1_err       <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            kill_q         <= kill_d;
            imem_req_valid <= req_valid_d;
            imem_req_addr  <= req_addr_d;
            IFU1_pc        <= slot_pc_d;
            IFU1_inst      <= slot_inst_d;
            IFU1_valid     <= slot_valid_d;
            IFU1_err       <= slot_err_d;
        end
    end

endmodule

// File: tb/tb_ysyx23060136_ifu_fetch_gen.sv
// Bench for ysyx23060136_ifu_fetch_gen: directed cycle table, then random
// traffic checked against an instruction-stream model of the fetch unit.
module tb_ysyx23060136_ifu_fetch_gen;

    localparam logic [31:0] B = 32'h8000_0000;
    localparam logic [31:0] Z = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        BRANCH_flushIF;
    logic [31:0] BRANCH_target;
    logic        FORWARD_stallIF;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic [31:0] IFU1_pc;
    logic [31:0] IFU1_inst;
    logic        IFU1_valid;
    logic        IFU1_err;

    always #5 clk = ~clk;

    ysyx23060136_ifu_fetch_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .BRANCH_flushIF  (BRANCH_flushIF),
        .BRANCH_target   (BRANCH_target),
        .FORWARD_stallIF (FORWARD_stallIF),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .IFU1_pc         (IFU1_pc),
        .IFU1_inst       (IFU1_inst),
        .IFU1_valid      (IFU1_valid),
        .IFU1_err        (IFU1_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents as seen by the bench.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Access-fault map for random traffic: one word per 1 KB region.
    function automatic logic err_at(input logic [31:0] a);
        return a[9:2] == 8'h0D;
    endfunction

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] target;
        logic        ready;
        logic        rvalid;
        logic        rerr;
        logic [31:0] raddr;
        logic        exp_rv;
        logic [31:0] exp_ra;
        logic        exp_iv;
        logic [31:0] exp_ipc;
        logic        exp_ierr;
    } vec_t;

    function automatic vec_t mk(input int s, input int f, input logic [31:0] t, input int r,
                                input int v, input int e, input logic [31:0] ra,
                                input int erv, input logic [31:0] era, input int eiv,
                                input logic [31:0] eipc, input int eerr);
        vec_t x;
        x.stall = (s != 0);   x.flush = (f != 0);  x.target = t;
        x.ready = (r != 0);   x.rvalid = (v != 0); x.rerr = (e != 0); x.raddr = ra;
        x.exp_rv = (erv != 0); x.exp_ra = era;     x.exp_iv = (eiv != 0);
        x.exp_ipc = eipc;      x.exp_ierr = (eerr != 0);
        return x;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0, 1:    return B + 32'($urandom_range(0, 255)) * 32'h4;
            2:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'h4;
            default: return 32'($urandom_range(0, 15)) * 32'h4;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    vec_t        vec [44];
    logic [31:0] exp_pc, paddr, prev_ra, prev_pc, prev_inst;
    logic        pending, halted, prev_hold_req, prev_stall_full, prev_err;
    logic        hs, redir, consume;
    int          cnt, idle;

    initial begin
        // Cycle-by-cycle directed run from reset release.
        vec[0]  = mk(0,0,Z,1,0,0,Z,               0,B,0,Z,0);
        vec[1]  = mk(0,0,Z,1,0,0,Z,               1,B,0,Z,0);
        vec[2]  = mk(0,0,Z,1,1,0,B,               0,B,0,Z,0);
        vec[3]  = mk(0,0,Z,1,0,0,Z,               0,B,1,B,0);
        vec[4]  = mk(0,0,Z,1,0,0,Z,               1,B+32'h4,0,Z,0);
        vec[5]  = mk(0,0,Z,1,1,0,B+32'h4,         0,B+32'h4,0,Z,0);
        for (int i = 6; i <= 10; i++)
            vec[i] = mk(1,0,Z,1,0,0,Z,            0,B+32'h4,1,B+32'h4,0);
        vec[11] = mk(0,0,Z,1,0,0,Z,               0,B+32'h4,1,B+32'h4,0);
        vec[12] = mk(0,0,Z,1,0,0,Z,               1,B+32'h8,0,Z,0);
        vec[13] = mk(0,0,Z,1,1,1,B+32'h8,         0,B+32'h8,0,Z,0);
        vec[14] = mk(1,0,Z,1,0,0,Z,               0,B+32'h8,1,B+32'h8,1);
        vec[15] = mk(0,0,Z,1,0,0,Z,               0,B+32'h8,1,B+32'h8,1);
        vec[16] = mk(1,1,B,1,0,0,Z,               0,B+32'h8,0,Z,0);
        vec[17] = mk(0,1,B,1,0,0,Z,               0,B+32'h8,0,Z,0);
        vec[18] = mk(0,0,Z,1,0,0,Z,               1,B,0,Z,0);
        vec[19] = mk(0,1,B+32'h100,1,0,0,Z,       0,B,0,Z,0);
        vec[20] = mk(0,0,Z,1,1,0,B,               0,B,0,Z,0);
        vec[21] = mk(0,0,Z,1,0,0,Z,               1,B+32'h100,0,Z,0);
        vec[22] = mk(0,0,Z,1,1,0,B+32'h100,       0,B+32'h100,0,Z,0);
        vec[23] = mk(1,1,B+32'h200,1,0,0,Z,       0,B+32'h100,1,B+32'h100,0);
        vec[24] = mk(0,0,Z,1,0,0,Z,               0,B+32'h100,1,B+32'h100,0);
        vec[25] = mk(0,0,Z,1,0,0,Z,               1,B+32'h104,0,Z,0);
        vec[26] = mk(0,0,Z,1,1,0,B+32'h104,       0,B+32'h104,0,Z,0);
        vec[27] = mk(0,0,Z,1,0,0,Z,               0,B+32'h104,1,B+32'h104,0);
        vec[28] = mk(0,1,32'hFFFF_FFFC,1,0,0,Z,   1,B+32'h108,0,Z,0);
        vec[29] = mk(0,0,Z,1,1,0,B+32'h108,       0,B+32'h108,0,Z,0);
        vec[30] = mk(0,0,Z,0,0,0,Z,               1,32'hFFFF_FFFC,0,Z,0);
        vec[31] = mk(0,0,Z,1,0,0,Z,               1,32'hFFFF_FFFC,0,Z,0);
        vec[32] = mk(0,0,Z,1,1,0,32'hFFFF_FFFC,   0,32'hFFFF_FFFC,0,Z,0);
        vec[33] = mk(0,0,Z,1,0,0,Z,               0,32'hFFFF_FFFC,1,32'hFFFF_FFFC,0);
        vec[34] = mk(0,0,Z,1,0,0,Z,               1,Z,0,Z,0);
        vec[35] = mk(0,1,B+32'h40,1,1,0,Z,        0,Z,0,Z,0);
        vec[36] = mk(0,1,B+32'h80,0,0,0,Z,        1,B+32'h40,0,Z,0);
        vec[37] = mk(0,0,Z,1,0,0,Z,               1,B+32'h40,0,Z,0);
        vec[38] = mk(0,0,Z,1,1,0,B+32'h40,        0,B+32'h40,0,Z,0);
        vec[39] = mk(0,0,Z,1,0,0,Z,               1,B+32'h80,0,Z,0);
        vec[40] = mk(0,0,Z,1,1,0,B+32'h80,        0,B+32'h80,0,Z,0);
        vec[41] = mk(0,0,Z,1,0,0,Z,               0,B+32'h80,1,B+32'h80,0);
        vec[42] = mk(0,0,Z,0,1,0,32'h1234,        1,B+32'h84,0,Z,0);
        vec[43] = mk(0,0,Z,0,0,0,Z,               1,B+32'h84,0,Z,0);

        rst_n = 1'b0;
        BRANCH_flushIF = 1'b0; BRANCH_target = '0; FORWARD_stallIF = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; imem_resp_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_req_addr",  imem_req_addr, B);
        chk("rst_ifu_valid", 32'(IFU1_valid), 32'h0);
        chk("rst_ifu_pc",    IFU1_pc, B);
        chk("rst_ifu_inst",  IFU1_inst, 32'h0);
        chk("rst_ifu_err",   32'(IFU1_err), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 44; i++) begin
            FORWARD_stallIF = vec[i].stall;
            BRANCH_flushIF  = vec[i].flush;
            BRANCH_target   = vec[i].target;
            imem_req_ready  = vec[i].ready;
            imem_resp_valid = vec[i].rvalid;
            imem_resp_err   = vec[i].rerr;
            imem_resp_data  = mem_word(vec[i].raddr);
            @(negedge clk);
            chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vec[i].exp_rv));
            chk($sformatf("vec%0d_req_addr", i),  imem_req_addr, vec[i].exp_ra);
            chk($sformatf("vec%0d_ifu_valid", i), 32'(IFU1_valid), 32'(vec[i].exp_iv));
            chk($sformatf("vec%0d_ifu_err", i),   32'(IFU1_err), 32'(vec[i].exp_ierr));
            if (vec[i].exp_iv) begin
                chk($sformatf("vec%0d_ifu_pc", i),   IFU1_pc, vec[i].exp_ipc);
                chk($sformatf("vec%0d_ifu_inst", i), IFU1_inst, mem_word(vec[i].exp_ipc));
            end
            @(posedge clk); #1;
        end

        // Asynchronous reset while a request is presented.
        FORWARD_stallIF = 1'b0; BRANCH_flushIF = 1'b0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("async_rst_req_addr",  imem_req_addr, B);
        chk("async_rst_ifu_valid", 32'(IFU1_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic against the instruction-stream model.
        exp_pc = B; pending = 1'b0; halted = 1'b0; cnt = 0; idle = 0; paddr = '0;
        prev_hold_req = 1'b0; prev_stall_full = 1'b0; prev_ra = '0;
        prev_pc = '0; prev_inst = '0; prev_err = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            FORWARD_stallIF = ($urandom_range(0, 99) < 25);
            BRANCH_flushIF  = ($urandom_range(0, 99) < 4);
            BRANCH_target   = pick_target();
            imem_req_ready  = ($urandom_range(0, 99) < 70);
            if (pending && cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(paddr);
                imem_resp_err   = err_at(paddr);
            end else if (!pending && $urandom_range(0, 99) < 5) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = $urandom;
                imem_resp_err   = 1'($urandom_range(0, 1));
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
                imem_resp_err   = 1'b0;
            end
            if (pending && cnt > 0) cnt--;

            @(negedge clk);
            hs      = imem_req_valid & imem_req_ready;
            redir   = BRANCH_flushIF & ~FORWARD_stallIF;
            consume = IFU1_valid & ~FORWARD_stallIF;

            if (pending) chk("single_outstanding", 32'(imem_req_valid), 32'h0);
            if (prev_hold_req) begin
                chk("req_hold_valid", 32'(imem_req_valid), 32'h1);
                chk("req_hold_addr",  imem_req_addr, prev_ra);
            end
            if (prev_stall_full) begin
                chk("stall_hold_valid", 32'(IFU1_valid), 32'h1);
                chk("stall_hold_pc",    IFU1_pc, prev_pc);
                chk("stall_hold_inst",  IFU1_inst, prev_inst);
                chk("stall_hold_err",   32'(IFU1_err), 32'(prev_err));
            end
            if (halted) chk("halt_no_req", 32'(imem_req_valid), 32'h0);
            if (IFU1_valid) begin
                chk("stream_pc",   IFU1_pc, exp_pc);
                chk("stream_inst", IFU1_inst, mem_word(exp_pc));
                chk("stream_err",  32'(IFU1_err), 32'(err_at(exp_pc)));
                if (IFU1_err) halted = 1'b1;
            end

            if (imem_resp_valid && pending) pending = 1'b0;
            if (hs) begin
                pending = 1'b1;
                paddr   = imem_req_addr;
                cnt     = $urandom_range(0, 2);
            end
            if (redir) begin
                exp_pc = BRANCH_target;
                halted = 1'b0;
            end else if (consume) begin
                exp_pc = exp_pc + 32'h4;
            end

            prev_hold_req   = imem_req_valid & ~imem_req_ready;
            prev_ra         = imem_req_addr;
            prev_stall_full = IFU1_valid & FORWARD_stallIF;
            prev_pc         = IFU1_pc;
            prev_inst       = IFU1_inst;
            prev_err        = IFU1_err;

            if (hs || imem_resp_valid || consume || redir || halted) idle = 0;
            else idle++;
            if (idle >= 64) begin
                chk("progress_watchdog", 32'(idle), 32'h0);
                idle = 0;
            end
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
